// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: drives single-outstanding reads to instruction memory
// and presents the word as decoded fields in a registered IF/ID stage, with a one-entry skid buffer.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        inst_valid,
  output logic [31:0] pc_out,
  output logic [5:0]  opCode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm32,
  output logic [1:0]  fsmState
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instrReg;
  logic [31:0] pcOutReg;
  logic        instValidReg;
  logic [31:0] skidData;
  logic [31:0] skidPc;
  logic        skidValid;

  // Memory handshake: imem_req stays high with imem_addr stable until the cycle
  // imem_ack=1 returns imem_data; that edge completes the request. Never more than one open.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign fsmState  = state;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      pc           <= {RESET_PC[31:2], 2'b00};
      instrReg     <= 32'h0;
      pcOutReg     <= 32'h0;
      instValidReg <= 1'b0;
      skidData     <= 32'h0;
      skidPc       <= 32'h0;
      skidValid    <= 1'b0;
    end else if (flush) begin
      // Redirect wins over everything, including an ack landing this cycle.
      state        <= FETCH;
      pc           <= {flush_target[31:2], 2'b00};
      instValidReg <= 1'b0;
      skidValid    <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack && !stall) begin
            instrReg     <= imem_data;
            pcOutReg     <= pc;
            instValidReg <= 1'b1;
            pc           <= pc + 32'd4;
          end else if (imem_ack && stall) begin
            skidData  <= imem_data;
            skidPc    <= pc;
            skidValid <= 1'b1;
            pc        <= pc + 32'd4;
            state     <= HOLD;
          end else if (!stall) begin
            instValidReg <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instrReg     <= skidData;
            pcOutReg     <= skidPc;
            instValidReg <= skidValid;
            skidValid    <= 1'b0;
            state        <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign inst_valid = instValidReg;
  assign pc_out     = pcOutReg;
  assign opCode     = instrReg[31:26];
  assign rs         = instrReg[25:21];
  assign rt         = instrReg[20:16];
  assign rd         = instrReg[15:11];
  assign funct      = instrReg[5:0];
  assign imm32      = {{16{instrReg[15]}}, instrReg[15:0]};

endmodule
